vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single-port ZX screen RAM (pixels 0x0000-0x17FF, attributes 0x1800-0x1AFF, 13-bit offsets) between the raster fetch engine and the Z80 bus.
- The raster engine has absolute priority, because its fetch slots are fixed to the pixel clock.
- CPU writes go into a one-entry posted-write buffer. CPU reads stall the Z80 through cpu_wait until their data returns.
- Sits between the video generator, the CPU bus decoder and the screen block RAM.

Parameters:
ADDR_W, 13, screen RAM address width
DATA_W, 8, screen RAM data width

Ports:
clk  in  1  pixel clock (25 MHz)
reset  in  1  synchronous, active-high
vid_req  in  1  one-cycle fetch strobe from the raster engine
vid_addr  in  ADDR_W  fetch address, valid with vid_req
vid_data  out  DATA_W  fetched byte
vid_valid  out  1  one-cycle pulse, vid_data valid
cpu_req  in  1  CPU access request; level, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
cpu_addr  in  ADDR_W  CPU address; stable while cpu_req
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  read data; held until the next read completes
cpu_ack  out  1  one-cycle pulse, request finished
cpu_wait  out  1  combinational: cpu_req & ~cpu_ack
stall_count  out  16  contention statistic (see Optional Feature)
mem_addr  out  ADDR_W  registered RAM address
mem_we  out  1  registered RAM write enable
mem_wdata  out  DATA_W  registered RAM write data
mem_rdata  in  DATA_W  synchronous RAM read data, valid one edge after the RAM samples mem_addr

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: vid_data=0, vid_valid=0, cpu_rdata=0, cpu_ack=0, mem_addr=0, mem_we=0, mem_wdata=0, stall_count=0. Write buffer is empty; CPU FSM is in C_IDLE; read pipeline is flushed.
- Issue slot: at most one RAM access is issued per edge. Priority, highest first:
  1. vid_req
  2. posted write buffer (wb_full)
  3. CPU read in C_PEND
- Video path: vid_req sampled at edge E → mem_addr=vid_addr, mem_we=0 at E. At E+2, vid_data=mem_rdata and vid_valid=1 for one cycle. Latency is fixed at 2 edges and is never delayed. Back-to-back vid_req every cycle is supported (pipelined tag per slot).
- Posted write:
  - Accept condition: cpu_req & cpu_we & ~wb_full & FSM C_IDLE.
  - At the accept edge: wb ← {cpu_addr, cpu_wdata}, wb_full=1, cpu_ack=1 next cycle.
  - If wb_full, the write waits (cpu_wait high) until the buffer drains.
  - Drain in the first slot without vid_req: mem_we=1 for exactly one cycle, wb_full=0 at the same edge.
  - A new write may be accepted at the same edge the buffer drains.
- CPU read FSM:
  - C_IDLE → C_PEND on cpu_req & ~cpu_we.
  - C_PEND → C_RD1 when the slot is free AND wb_full=0. Reads never bypass a buffered write, which guarantees read-after-write ordering. This edge issues mem_addr=cpu_addr, mem_we=0.
  - C_RD1 → C_RD2 unconditionally.
  - C_RD2: cpu_rdata=mem_rdata, cpu_ack=1; → C_ACK.
  - C_ACK → C_IDLE. This is a one-cycle turnaround, so the held cpu_req is not re-accepted. The bus decoder drops cpu_req in the ack cycle.
  - Minimum read latency: cpu_req at edge E → cpu_ack high after edge E+3.
- Simultaneous events:
  - vid_req together with a pending CPU read or write: video wins; the CPU access retries at the next edge.
  - vid_req together with a write accept: both happen. The accept only loads the buffer; it does not use the RAM slot.
- mem_we is deasserted in every cycle except write-drain cycles.
- Reset asserted mid-operation drops any buffered write (lost) and any in-flight read (no ack). vid_valid is suppressed for in-flight fetches.

Optional Feature:
- Macro: VRAM_STATS_EN.
- Defined: stall_count increments on every cycle with cpu_wait=1 and saturates at 0xFFFF. It is cleared by reset, and also cleared on a cpu_ack edge that completes a write to address 0x1FFF.
- Undefined: stall_count is constant 0; no counter logic is generated.

Test Plan:
- Reset, then vid_req with vid_addr=0x0123 and mem_rdata model returning 0xA5 → at +2 edges vid_data=0xA5, vid_valid one cycle; mem_we stays 0.
- Idle CPU write to 0x1800 with data 0x47 → cpu_ack after 1 edge; next cycle mem_we=1, mem_addr=0x1800, mem_wdata=0x47, for one cycle only.
- CPU write to 0x0010 (0x5A) while vid_req pulses every cycle for 5 cycles → write accepted and acked immediately; mem_we asserts only on the first edge after vid_req stops.
- CPU write 0x0020←0x3C immediately followed by a read of 0x0020 → read issues only after the drain; cpu_rdata=0x3C; no cpu_ack before the write reaches RAM.
- CPU read with no contention → cpu_ack 3 edges after cpu_req. Same read with vid_req in the issue cycle → ack slips by exactly 1.
- VRAM_STATS_EN defined: a read stalled by 2 vid_req cycles gives stall_count=5. Reset mid-read: no cpu_ack, stall_count=0, mem_we=0.

Source files
------------

// File: rtl/vram_arbiter.sv
// Screen RAM arbiter: raster fetches first, then the posted CPU write, then CPU reads.
// Optional VRAM_STATS_EN builds the cpu_wait contention counter on stall_count.
//
// state  | meaning
// C_IDLE | no CPU read in progress; CPU writes can be accepted
// C_PEND | read requested, waiting for a free slot and an empty write buffer
// C_RD1  | read address is on mem_addr
// C_RD2  | RAM is returning the read byte
// C_ACK  | ack cycle; the held cpu_req is ignored
module vram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait,
  output logic [15:0]       stall_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {C_IDLE, C_PEND, C_RD1, C_RD2, C_ACK} cpu_state_t;

  cpu_state_t        state_q, state_d;
  logic              wb_full;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              vid_p1, vid_p2;
  logic              drain, rd_issue, wb_load;

  assign cpu_wait = cpu_req & ~cpu_ack;

  always_comb begin
    state_d  = state_q;
    drain    = ~vid_req & wb_full;
    rd_issue = ~vid_req & ~wb_full & (state_q == C_PEND);
    // The buffer slot frees on the drain edge, so a new write can land on the same edge.
    wb_load  = cpu_req & cpu_we & ~cpu_ack & (state_q == C_IDLE) & (~wb_full | drain);
    case (state_q)
      C_IDLE:  if (cpu_req & ~cpu_we & ~cpu_ack) state_d = C_PEND;
      C_PEND:  if (rd_issue) state_d = C_RD1;
      C_RD1:   state_d = C_RD2;
      C_RD2:   state_d = C_ACK;
      C_ACK:   state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= C_IDLE;
      wb_full   <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      vid_p1    <= 1'b0;
      vid_p2    <= 1'b0;
      vid_valid <= 1'b0;
      vid_data  <= '0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      state_q <= state_d;
      // Tag pipeline follows each fetch through address and RAM-output stages.
      vid_p1    <= vid_req;
      vid_p2    <= vid_p1;
      vid_valid <= vid_p2;
      if (vid_p2) vid_data <= mem_rdata;

      mem_we <= drain;
      if (vid_req) begin
        mem_addr <= vid_addr;
      end else if (drain) begin
        mem_addr  <= wb_addr;
        mem_wdata <= wb_data;
      end else if (rd_issue) begin
        mem_addr <= cpu_addr;
      end

      if (wb_load) begin
        wb_full <= 1'b1;
        wb_addr <= cpu_addr;
        wb_data <= cpu_wdata;
      end else if (drain) begin
        wb_full <= 1'b0;
      end

      cpu_ack <= wb_load | (state_q == C_RD2);
      if (state_q == C_RD2) cpu_rdata <= mem_rdata;
    end
  end

`ifdef VRAM_STATS_EN
  logic [15:0] stall_q;

  // A completed write to the last offset doubles as a software clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (wb_load && (cpu_addr == ADDR_W'(13'h1FFF))) begin
      stall_q <= '0;
    end else if (cpu_wait && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: table of CPU transactions, directed corner sequences,
// and a randomized run against a shadow memory and a fixed-latency video model.
module tb_vram_arbiter;
  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_wait;
  logic [15:0]   stall_count;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .stall_count(stall_count),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #20 clk = ~clk;

  // Synchronous single-port RAM, read-before-write.
  logic [7:0]  ram [0:8191];
  logic        ram_clr = 1'b0;
  logic        pl_en = 1'b0;
  logic [12:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 8192; i++) ram[i] <= 8'h00;
    end else begin
      if (pl_en) ram[pl_addr] <= pl_data;
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one CPU access; vmask bit i drives vid_req into the i-th edge of the access.
  task automatic cpu_op(input logic we, input logic [12:0] a, input logic [7:0] d,
                        input logic [7:0] vmask, output int cnt, output logic [7:0] rd);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    vid_addr = 13'h0AAA;
    vid_req = vmask[0];
    cnt = 0;
    while (cnt < 30) begin
      tick();
      cnt++;
      vid_req = (cnt < 8) ? vmask[cnt[2:0]] : 1'b0;
      if (cpu_ack) break;
    end
    rd = cpu_rdata;
    if (!cpu_ack) begin
      checks++; errors++;
      $display("FAIL cpu_op_timeout: no cpu_ack within %0d edges, addr 0x%0h", cnt, a);
    end
    cpu_req = 1'b0;
    vid_req = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [12:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  vmask;
    int          exp_cnt;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t        vt [9];
  int          cnt;
  logic [7:0]  rd;
  logic [7:0]  shadow [0:8191];

  // random-phase state
  int          cyc, op_edges, gap, writes, drains, stall_m;
  logic        op_active, op_we, w_drv, vv;
  logic [12:0] op_addr, va, s0_a;
  logic        s0_v, s1_v;
  logic [7:0]  s1_d;
  localparam int NCYC = 3000;

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 13'h0100, 8'h11, 8'b000, 1, 8'h00};
    vt[1] = '{1'b0, 13'h0100, 8'h00, 8'b000, 4, 8'h11};
    vt[2] = '{1'b0, 13'h0100, 8'h00, 8'b010, 5, 8'h11};
    vt[3] = '{1'b1, 13'h0005, 8'h99, 8'b001, 1, 8'h00};
    vt[4] = '{1'b0, 13'h0005, 8'h00, 8'b001, 4, 8'h99};
    vt[5] = '{1'b0, 13'h0005, 8'h00, 8'b110, 6, 8'h99};
    vt[6] = '{1'b0, 13'h1AFF, 8'h00, 8'b000, 4, 8'h00};
    vt[7] = '{1'b1, 13'h1AFF, 8'hC3, 8'b000, 1, 8'h00};
    vt[8] = '{1'b0, 13'h1AFF, 8'h00, 8'b000, 4, 8'hC3};

    reset = 1'b1; vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ram_clr = 1'b1;
    tick(); tick();
    ram_clr = 1'b0;
    pl_en = 1'b1; pl_addr = 13'h0123; pl_data = 8'hA5;
    tick();
    pl_en = 1'b0;
    tick();

    chk("rst_vid_data", vid_data, 0);
    chk("rst_vid_valid", vid_valid, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_stall_count", stall_count, 0);
    chk("rst_cpu_wait", cpu_wait, 0);
    reset = 1'b0;
    tick();

    // video fetch, fixed two-edge latency
    vid_req = 1'b1; vid_addr = 13'h0123;
    tick();
    vid_req = 1'b0;
    chk("vid_issue_addr", mem_addr, 13'h0123);
    chk("vid_e0_valid", vid_valid, 0);
    chk("vid_e0_we", mem_we, 0);
    tick();
    chk("vid_e1_valid", vid_valid, 0);
    tick();
    chk("vid_e2_valid", vid_valid, 1);
    chk("vid_e2_data", vid_data, 8'hA5);
    chk("vid_e2_we", mem_we, 0);
    tick();
    chk("vid_e3_valid", vid_valid, 0);

    // idle write: ack after one edge, single drain cycle next
    cpu_op(1'b1, 13'h1800, 8'h47, 8'b0, cnt, rd);
    chk("wr_ack_lat", cnt, 1);
    chk("wr_e0_we", mem_we, 0);
    tick();
    chk("wr_drain_we", mem_we, 1);
    chk("wr_drain_addr", mem_addr, 13'h1800);
    chk("wr_drain_data", mem_wdata, 8'h47);
    tick();
    chk("wr_drain_once", mem_we, 0);

    // write accepted under continuous video, drains after the last fetch
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0010; cpu_wdata = 8'h5A;
    vid_req = 1'b1; vid_addr = 13'h0200;
    tick();
    chk("wrv_ack", cpu_ack, 1);
    chk("wrv_we_e1", mem_we, 0);
    cpu_req = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk("wrv_we_blocked", mem_we, 0);
    end
    vid_req = 1'b0;
    tick();
    chk("wrv_drain_we", mem_we, 1);
    chk("wrv_drain_addr", mem_addr, 13'h0010);
    chk("wrv_drain_data", mem_wdata, 8'h5A);
    tick();
    chk("wrv_drain_once", mem_we, 0);

    // read-after-write: read waits for the buffered write to reach RAM
    cpu_op(1'b1, 13'h0020, 8'h3C, 8'b0, cnt, rd);
    chk("raw_wr_ack", cnt, 1);
    vid_req = 1'b1; vid_addr = 13'h0300;
    tick();
    cpu_op(1'b0, 13'h0020, 8'h00, 8'b001, cnt, rd);
    chk("raw_rd_lat", cnt, 5);
    chk("raw_rd_data", rd, 8'h3C);
    chk("raw_ram", ram[13'h0020], 8'h3C);

    // table of CPU transactions with video contention masks
    for (int i = 0; i < 9; i++) begin
      tick();
      cpu_op(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].vmask, cnt, rd);
      chk($sformatf("tbl%0d_lat", i), cnt, vt[i].exp_cnt);
      if (!vt[i].we) chk($sformatf("tbl%0d_rdata", i), rd, vt[i].exp_rd);
    end

    // contention statistic
    tick();
    reset = 1'b1; tick(); reset = 1'b0; tick();
    cpu_op(1'b0, 13'h1800, 8'h00, 8'b011, cnt, rd);
    chk("stat_rd_lat", cnt, 5);
    chk("stat_rd_data", rd, 8'h47);
`ifdef VRAM_STATS_EN
    chk("stat_count5", stall_count, 5);
    tick();
    cpu_op(1'b1, 13'h1FFF, 8'h01, 8'b0, cnt, rd);
    chk("stat_clear_1fff", stall_count, 0);
`else
    chk("stat_disabled", stall_count, 0);
`endif
    tick(); tick();

    // reset in the middle of a read and a video fetch
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1800;
    vid_req = 1'b1; vid_addr = 13'h0123;
    tick();
    vid_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; cpu_req = 1'b0;
    chk("rstm_stall", stall_count, 0);
    chk("rstm_we", mem_we, 0);
    for (int i = 0; i < 5; i++) begin
      chk("rstm_no_ack", cpu_ack, 0);
      chk("rstm_no_valid", vid_valid, 0);
      tick();
    end

    // reset drops a buffered write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0030; cpu_wdata = 8'h77;
    vid_req = 1'b1; vid_addr = 13'h0400;
    tick();
    chk("rstw_ack", cpu_ack, 1);
    cpu_req = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; vid_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstw_no_drain", mem_we, 0);
    end
    chk("rstw_ram", ram[13'h0030], 8'h00);

    // randomized traffic
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    for (int i = 0; i < 8192; i++) shadow[i] = ram[i];
    cyc = 0; op_edges = 0; gap = 0; writes = 0; drains = 0; stall_m = 0;
    op_active = 1'b0; op_we = 1'b0; op_addr = '0;
    s0_v = 1'b0; s0_a = '0; s1_v = 1'b0; s1_d = '0;
    while ((cyc < NCYC + 8 || op_active) && cyc < NCYC + 300) begin
      w_drv = cpu_req; vv = vid_req; va = vid_addr;
      tick();
      cyc++;
      if (w_drv && stall_m < 65535) stall_m++;

      chk("rnd_vid_valid", vid_valid, s1_v);
      if (s1_v) chk("rnd_vid_data", vid_data, s1_d);
      s1_v = s0_v; s1_d = ram[s0_a];
      s0_v = vv; s0_a = va;

      if (mem_we) begin
        drains++;
        chk("rnd_we_during_vid", vv, 0);
      end
`ifdef VRAM_STATS_EN
      chk("rnd_stall", stall_count, stall_m);
`else
      chk("rnd_stall", stall_count, 0);
`endif
      chk("rnd_cpu_wait", cpu_wait, cpu_req & ~cpu_ack);

      if (op_active) begin
        op_edges++;
        if (cpu_ack) begin
          if (!op_we) chk("rnd_rdata", cpu_rdata, shadow[op_addr]);
          chk("rnd_ack_bound", op_edges <= 60, 1);
          op_active = 1'b0; cpu_req = 1'b0; gap = 1;
        end else if (op_edges > 60) begin
          checks++; errors++;
          $display("FAIL rnd_ack_timeout: addr 0x%0h we %0d", op_addr, op_we);
          op_active = 1'b0; cpu_req = 1'b0; gap = 1;
        end
      end else begin
        chk("rnd_spurious_ack", cpu_ack, 0);
        if (gap > 0) begin
          gap--;
        end else if (cyc < NCYC && $urandom_range(0, 2) == 0) begin
          op_active = 1'b1; op_edges = 0;
          op_we = $urandom_range(0, 1) == 1;
          op_addr = 13'($urandom_range(0, 15)) | (($urandom_range(0, 1) == 1) ? 13'h1800 : 13'h0000);
          cpu_req = 1'b1; cpu_we = op_we; cpu_addr = op_addr;
          cpu_wdata = 8'($urandom_range(0, 255));
          if (op_we) begin
            shadow[op_addr] = cpu_wdata;
            writes++;
          end
        end
      end

      if (cyc < NCYC) begin
        vid_req = ($urandom_range(0, 7) < 3);
        vid_addr = 13'($urandom_range(0, 8191));
      end else begin
        vid_req = 1'b0;
      end
    end
    chk("rnd_drain_count", drains, writes);
    for (int i = 0; i < 16; i++) begin
      chk("rnd_ram_lo", ram[13'(i)], shadow[13'(i)]);
      chk("rnd_ram_attr", ram[13'h1800 + 13'(i)], shadow[13'h1800 + 13'(i)]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
